// File: rtl/div_arbiter.sv
// div_arbiter: two-requester round-robin front end for one shared
// iterative divider. Operands are registered at grant so the divider
// never sees a combinational path from the requesters. Divisors that are
// zero or negative bypass the divider and answer immediately.
module div_arbiter #(
  parameter logic [31:0] ZQ = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [31:0] x1,
  input  logic [31:0] y1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  input  logic        rsp_ack,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        err,
  output logic        div_run,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic        div_stall,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;     // last requester served
  logic        gnt_q, gnt_d;     // owner of the operation in flight
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        err_q, err_d;
  logic        gnt_any;          // a grant happens this cycle
  logic        gsel;             // which requester is granted
  logic [31:0] gx, gy;

  // Next-state: arbitration in IDLE, capture in BUSY, handshake in RESP
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    x_d     = x_q;
    y_d     = y_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    gnt_any = 1'b0;
    gsel    = 1'b0;
    gx      = x0;
    gy      = y0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_any = 1'b1;
          // Contended: the one not served last wins; otherwise whoever asks
          gsel    = (req0 && req1) ? ~ptr_q : req1;
          gx      = gsel ? x1 : x0;
          gy      = gsel ? y1 : y0;
          ptr_d   = gsel;
          gnt_d   = gsel;
          x_d     = gx;
          y_d     = gy;
          if (gy == 32'd0 || gy[31]) begin
            quot_d  = ZQ;
            rem_d   = gx;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!div_stall) begin
          quot_d  = div_quot;
          rem_d   = div_rem;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      gnt_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Ack is a grant-cycle pulse, forced low while reset is asserted
  assign ack0    = gnt_any && !gsel && !rst;
  assign ack1    = gnt_any &&  gsel && !rst;
  assign done0   = (state_q == RESP) && !gnt_q;
  assign done1   = (state_q == RESP) &&  gnt_q;
  // Run is low outside BUSY so the divider step counter restarts each time
  assign div_run = (state_q == BUSY);
  assign div_x   = x_q;
  assign div_y   = y_q;
  assign quot    = quot_q;
  assign rem     = rem_q;
  assign err     = err_q;

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter ZQ, default 32'hFFFFFFFF: quotient returned on an illegal divisor.
REQ-002 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0, req1  input  1  requester n has an operation pending.
REQ-005 SHALL have ports x0, y0, x1, y1  input  32  dividend and divisor of requester n; stable while reqn is high.
REQ-006 SHALL have ports ack0, ack1  output  1  one-cycle pulse: requester n's operands accepted.
REQ-007 SHALL have ports done0, done1  output  1  result for requester n valid, held until acknowledged.
REQ-008 SHALL have port rsp_ack  input  1  owner of the asserted donen consumes the result.
REQ-009 SHALL have ports quot, rem  output  32  registered result of the current response.
REQ-010 SHALL have port err  output  1  registered flag: divisor was zero or negative.
REQ-011 SHALL have port div_run  output  1  run input of the shared divider.
REQ-012 SHALL have ports div_x, div_y  output  32  operand inputs of the shared divider.
REQ-013 SHALL have port div_stall  input  1  stall output of the shared divider.
REQ-014 SHALL have ports div_quot, div_rem  input  32  result outputs of the shared divider.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-016 SHALL, in IDLE with at least one reqn high, grant one requester per cycle and pulse that requester's ackn in the grant cycle.
REQ-017 SHALL arbitrate round-robin: when both req are high, grant the requester not served last; the last-served pointer resets to 1, so requester 0 wins first.
REQ-018 SHALL latch the granted x and y into operand registers at grant; div_x and div_y SHALL be driven from these registers only.
REQ-019 SHALL treat divisor y==0 or y[31]==1 as illegal: skip BUSY and go from IDLE straight to RESP with quot=ZQ, rem=x, err=1.
REQ-020 SHALL, for a legal divisor, go to BUSY and hold div_run=1 through BUSY.
REQ-021 SHALL hold div_run=0 in IDLE and RESP, so the divider's internal step counter clears before every operation.
REQ-022 SHALL, in BUSY in the cycle div_stall==0, capture div_quot and div_rem into quot and rem, set err=0, and go to RESP.
REQ-023 SHALL produce this BUSY timing: div_run high for exactly 32 cycles; capture in the 32nd; done asserted in the following cycle.
REQ-024 SHALL, in RESP, assert only the donen of the granted requester.
REQ-025 SHALL, in RESP with rsp_ack high, drop donen in the next cycle and return to IDLE.
REQ-026 SHALL ignore rsp_ack outside RESP.
REQ-027 SHALL grant at most one new operation per two cycles, since RESP to IDLE costs one cycle.
REQ-028 SHALL ignore a reqn that falls after its ackn; a reqn that falls before grant is not served.
REQ-029 SHALL keep quot, rem and err unchanged outside the capture cycle and the illegal-divisor grant cycle.
REQ-030 SHALL implement no combinational path from any reqn or xn/yn input to div_x, div_y or div_run.

Reset
REQ-031 SHALL, on rst, immediately enter IDLE and set ack0=ack1=0, done0=done1=0, div_run=0, quot=0, rem=0, err=0, operand registers=0 and pointer=1.
REQ-032 SHALL, on rst asserted in BUSY, abort the operation and return no result; the divider restarts at the next grant because div_run is low.

Verification
REQ-033 SHALL cover: req0, x0=100, y0=7 -> ack0 pulse; div_run high for 32 cycles; done0 with quot=14, rem=2, err=0; cleared by rsp_ack.
REQ-034 SHALL cover: req1, x1=-7 (32'hFFFFFFF9), y1=2 -> quot=-4 (32'hFFFFFFFC), rem=1, err=0 (floored division).
REQ-035 SHALL cover: req0 and req1 raised in the same cycle out of reset, each with operands 9/4, rsp_ack sent promptly -> requester 0 served first with quot=2, rem=1, then requester 1, alternating thereafter.
REQ-036 SHALL cover: req0 with y0=0, then y0=32'h80000000 -> no div_run pulse; done0 the cycle after ack0; quot=32'hFFFFFFFF, rem=x0, err=1.
REQ-037 SHALL cover: rsp_ack held low for 10 cycles in RESP -> done0, quot, rem stable all 10 cycles; no new grant.
REQ-038 SHALL cover: rst pulsed at BUSY cycle 15, then a new request 50/5 -> all outputs 0 during reset; new result quot=10, rem=0 after a full 32-cycle run.
